// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-ported memory between instruction fetch
// (IF) and load/store (DM). One transaction in flight at a time over a
// req/gnt/rvalid handshake. DM wins arbitration by default because the MEM
// stage holds the older instruction.
//
// Build option: define ARB_FAIRNESS_EN to add a starvation counter. IF is then
// forced to win once it has lost STARVE_LIMIT contested arbitrations in a row.
module riscv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // instruction fetch requester
    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [XLEN-1:0]     if_rdata_o,
    // load/store requester
    input  logic                dm_req_i,
    input  logic                dm_we_i,
    input  logic [XLEN/8-1:0]   dm_be_i,
    input  logic [XLEN-1:0]     dm_addr_i,
    input  logic [XLEN-1:0]     dm_wdata_i,
    output logic                dm_gnt_o,
    output logic                dm_rvalid_o,
    output logic [XLEN-1:0]     dm_rdata_o,
    // unified memory
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,
    output logic                busy_o
);

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // The starve counter is 4 bits wide, so the limit must fit.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("riscv_mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   arb_any;   // someone wants the memory
    logic   arb_dm;    // DM wins if we arbitrate this cycle
    logic   arb_take;  // an arbitration decision is committed this cycle

    assign arb_any = if_req_i | dm_req_i;

`ifdef ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       force_if;

    assign force_if = if_req_i && (starve_q == LIMIT4);
    assign arb_dm   = dm_req_i && !force_if;

    // Count contested DM wins; any IF win resets the streak.
    always_comb begin
        starve_d = starve_q;
        if (arb_take) begin
            if (!arb_dm)
                starve_d = 4'd0;
            else if (if_req_i && starve_q != 4'hf)
                starve_d = starve_q + 4'd1;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) starve_q <= 4'd0;
        else       starve_q <= starve_d;
    end
`else
    assign arb_dm = dm_req_i;
`endif

    // State and owner registers; reset drops any in-flight response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next state: arbitrate from IDLE or straight out of RSP (back-to-back).
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        arb_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_any) arb_take = 1'b1;
            end
            S_REQ: begin
                if (mem_gnt_i) state_d = S_RSP;
            end
            S_RSP: begin
                if (mem_rvalid_i) begin
                    if (arb_any) arb_take = 1'b1;
                    else         state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (arb_take) begin
            state_d = S_REQ;
            owner_d = arb_dm ? OWN_DM : OWN_IF;
        end
    end

    // Outputs: memory side driven only in REQ, responses routed only in RSP.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        dm_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        dm_rdata_o  = '0;
        case (state_q)
            S_REQ: begin
                mem_req_o = 1'b1;
                if (owner_q == OWN_DM) begin
                    mem_we_o    = dm_we_i;
                    mem_be_o    = dm_be_i;
                    mem_addr_o  = dm_addr_i;
                    mem_wdata_o = dm_wdata_i;
                    dm_gnt_o    = mem_gnt_i;
                end else begin
                    mem_be_o    = '1;
                    mem_addr_o  = if_addr_i;
                    if_gnt_o    = mem_gnt_i;
                end
            end
            S_RSP: begin
                // Read data goes to both sides; only the owner sees rvalid.
                if_rdata_o = mem_rdata_i;
                dm_rdata_o = mem_rdata_i;
                if (owner_q == OWN_DM) dm_rvalid_o = mem_rvalid_i;
                else                   if_rvalid_o = mem_rvalid_i;
            end
            default: ;
        endcase
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: single fetch, collision, store with
// wait states, spurious response, reset mid-transaction, and fairness (or
// its absence, depending on ARB_FAIRNESS_EN). A monitor also checks that the
// bench never drops or changes a request before it is granted.
module tb_riscv_mem_arbiter;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            if_req_i;
    logic [XLEN-1:0] if_addr_i;
    logic            if_gnt_o, if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            dm_req_i, dm_we_i;
    logic [3:0]      dm_be_i;
    logic [XLEN-1:0] dm_addr_i, dm_wdata_i;
    logic            dm_gnt_o, dm_rvalid_o;
    logic [XLEN-1:0] dm_rdata_o;
    logic            mem_req_o, mem_we_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o;
    logic            mem_gnt_i, mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_be_i(dm_be_i),
        .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o),
        .dm_rvalid_o(dm_rvalid_o), .dm_rdata_o(dm_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Requester protocol: once asserted, req and controls hold until gnt.
    logic        if_pend = 1'b0, dm_pend = 1'b0;
    logic [31:0] if_prev;
    logic [68:0] dm_prev;
    always @(negedge clk) begin
        if (!rst_i && if_pend)
            chk("if_hold", {if_req_i, if_addr_i}, {1'b1, if_prev});
        if (!rst_i && dm_pend)
            chk("dm_hold", {dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i}, {1'b1, dm_prev});
        if_pend = if_req_i && !if_gnt_o && !rst_i;
        dm_pend = dm_req_i && !dm_gnt_o && !rst_i;
        if_prev = if_addr_i;
        dm_prev = {dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i};
    end

    // expected winners for ten contested arbitrations (1 = DM)
    logic [9:0] fair_exp;

    initial begin
        rst_i = 1'b1;
        if_req_i = 0; if_addr_i = '0;
        dm_req_i = 0; dm_we_i = 0; dm_be_i = '0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;

        // reset state
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, 0);
        chk("rst_rsp", {if_gnt_o, dm_gnt_o, if_rvalid_o, dm_rvalid_o}, 0);
        step(); rst_i = 0;

        // single fetch, zero-wait memory
        if_req_i = 1; if_addr_i = 32'h100;
        @(negedge clk);
        chk("f_idle", {busy_o, mem_req_o, if_gnt_o}, 0);
        step(); mem_gnt_i = 1;
        @(negedge clk);
        chk("f_req", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o}, {1'b1, 1'b0, 4'hf, 32'h100});
        chk("f_gnt", {if_gnt_o, dm_gnt_o, busy_o}, 3'b101);
        step(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h00500093;
        @(negedge clk);
        chk("f_rsp", {if_rvalid_o, dm_rvalid_o, mem_req_o}, 3'b100);
        chk("f_rdata", if_rdata_o, 32'h00500093);
        step(); mem_rvalid_i = 0;
        @(negedge clk);
        chk("f_done", {busy_o, if_rvalid_o}, 0);

        // collision: DM first, IF back-to-back without an IDLE cycle
        step();
        if_req_i = 1; if_addr_i = 32'h104;
        dm_req_i = 1; dm_we_i = 0; dm_be_i = 4'hf; dm_addr_i = 32'h2000;
        step(); mem_gnt_i = 1;
        @(negedge clk);
        chk("c_dm_req", {dm_gnt_o, if_gnt_o, mem_addr_o}, {2'b10, 32'h2000});
        step(); dm_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11223344;
        @(negedge clk);
        chk("c_dm_rsp", {dm_rvalid_o, if_rvalid_o, dm_rdata_o}, {2'b10, 32'h11223344});
        step(); mem_rvalid_i = 0; mem_gnt_i = 1;
        @(negedge clk);
        chk("c_if_b2b", {busy_o, mem_req_o, if_gnt_o, dm_gnt_o, mem_addr_o}, {4'b1110, 32'h104});
        step(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        @(negedge clk);
        chk("c_if_rsp", {if_rvalid_o, dm_rvalid_o, if_rdata_o}, {2'b10, 32'h55});
        step(); mem_rvalid_i = 0;
        @(negedge clk);
        chk("c_done", busy_o, 0);

        // store with three wait states
        step();
        dm_req_i = 1; dm_we_i = 1; dm_be_i = 4'b0011; dm_addr_i = 32'h3000; dm_wdata_i = 32'hDEADBEEF;
        step();
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk("s_wait", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, dm_gnt_o},
                {1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF, 1'b0});
            step();
        end
        mem_gnt_i = 1;
        @(negedge clk);
        chk("s_gnt", {dm_gnt_o, if_gnt_o, mem_we_o}, 3'b101);
        step(); dm_req_i = 0; dm_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
        @(negedge clk);
        chk("s_rsp", {dm_rvalid_o, mem_req_o, mem_we_o, mem_wdata_o}, {3'b100, 32'h0});
        step(); mem_rvalid_i = 0;

        // spurious response and grant while IDLE
        step(); mem_rvalid_i = 1; mem_gnt_i = 1; mem_rdata_i = 32'hBAD;
        @(negedge clk);
        chk("sp_idle", {if_rvalid_o, dm_rvalid_o, if_gnt_o, dm_gnt_o, busy_o}, 0);
        step(); mem_rvalid_i = 0; mem_gnt_i = 0;
        @(negedge clk);
        chk("sp_stay", {busy_o, mem_req_o}, 0);

        // reset while waiting for the response
        step(); dm_req_i = 1; dm_addr_i = 32'h4000; dm_be_i = 4'hf;
        step(); mem_gnt_i = 1;
        step(); dm_req_i = 0; mem_gnt_i = 0;
        @(negedge clk);
        chk("r_in_rsp", busy_o, 1);
        step(); rst_i = 1;
        #1;
        chk("r_async", {busy_o, mem_req_o, dm_rvalid_o, if_rvalid_o}, 0);
        step(); rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        @(negedge clk);
        chk("r_late", {dm_rvalid_o, if_rvalid_o, busy_o}, 0);
        step(); mem_rvalid_i = 0;

        // both requesters hammering a zero-wait memory
`ifdef ARB_FAIRNESS_EN
        fair_exp = 10'b0111101111; // bit t = transaction t: DM x4, IF, DM x4, IF
`else
        fair_exp = 10'b1111111111;
`endif
        step();
        if_req_i = 1; if_addr_i = 32'h200;
        dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h5000;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
        for (int t = 0; t < 10; t++) begin
            step();
            @(negedge clk);
            chk($sformatf("fair_%0d", t), {dm_gnt_o, if_gnt_o}, {fair_exp[t], ~fair_exp[t]});
            step();
        end
        dm_req_i = 0;
        step();
        @(negedge clk);
        chk("fair_if_tail", {if_gnt_o, mem_addr_o}, {1'b1, 32'h200});
        step(); if_req_i = 0;
        step(); mem_gnt_i = 0; mem_rvalid_i = 0;
        @(negedge clk);
        chk("fair_idle", busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-ported memory between instruction fetch (IF requester) and load/store (data requester, "dm") in the 5-stage core.
- Sits between IF/MEM stages and the unified memory; sequences one transaction at a time over a req/gnt/rvalid handshake.
- Data requests win by default because the MEM stage holds the older instruction; IF sees stalls as a withheld grant.

Parameters:
- XLEN, 32, data/address width.
- STARVE_LIMIT, 4, consecutive IF losses before IF is forced to win (used only with ARB_FAIRNESS_EN); range 1..15.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- if_req_i  in  1  fetch request; held with address until if_gnt_o
- if_addr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch accepted by memory
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  XLEN  fetch data
- dm_req_i  in  1  data request; held with controls until dm_gnt_o
- dm_we_i  in  1  1=store, 0=load
- dm_be_i  in  XLEN/8  byte enables
- dm_addr_i  in  XLEN  data address
- dm_wdata_i  in  XLEN  store data
- dm_gnt_o  out  1  data accepted
- dm_rvalid_o  out  1  load data valid / store complete
- dm_rdata_o  out  XLEN  load data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  write enable to memory
- mem_be_o  out  XLEN/8  byte enables to memory
- mem_addr_o  out  XLEN  address to memory
- mem_wdata_o  out  XLEN  write data to memory
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  XLEN  memory read data
- busy_o  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, RSP. Registered owner bit (0=IF, 1=DM). Reset: state=IDLE, owner=0, starve counter=0; all outputs 0.
- IDLE: if dm_req_i, owner<=DM, go REQ; else if if_req_i, owner<=IF, go REQ; else stay.
- REQ: mem_req_o=1; mem_addr/we/be/wdata muxed from owner (IF: we=0, be=all ones, wdata=0). In any state other than REQ, mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are 0.
- REQ: owner's gnt_o = mem_gnt_i, combinational, same cycle. The non-owner's gnt_o is 0. On mem_gnt_i go RSP, else hold REQ. Wait states are unbounded.
- RSP: owner's rvalid_o = mem_rvalid_i. Both rdata_o = mem_rdata_i unconditionally; data is meaningful only with rvalid. Stores also complete by rvalid.
- RSP exit on mem_rvalid_i: if any request is pending, arbitrate as in IDLE and go directly to REQ (back-to-back); else go IDLE.
- Latency: request sampled in IDLE -> mem_req_o next cycle. With zero-wait memory (gnt same cycle, rvalid next cycle), throughput is 1 transaction per 2 cycles.
- Exactly one outstanding transaction.
- mem_rvalid_i outside RSP is ignored; no rvalid_o is generated.
- mem_gnt_i outside REQ is ignored.
- Requester deasserting req or changing controls before gnt is a protocol violation; bench asserts on it.
- Arbiter keeps its registered owner even if the owner's req drops mid-REQ.
- Reset mid-transaction: immediate return to IDLE, outputs 0; the in-flight response is discarded.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined: 4-bit starve counter increments each arbitration where both requests are present and DM wins; it clears when IF wins. When counter == STARVE_LIMIT and if_req_i is high, IF wins that arbitration.
- Undefined: fixed DM priority; counter logic absent; STARVE_LIMIT unused.

Test Plan:
- Single fetch: if_req_i=1, addr=0x100, mem_gnt_i immediate, rvalid next cycle with rdata=0x00500093 -> mem_req_o high 1 cycle after req, if_rvalid_o=1 with if_rdata_o=0x00500093, busy_o drops after.
- Collision: if_req_i and dm_req_i (load, addr=0x2000) rise together -> DM served first; IF gnt follows back-to-back with no IDLE cycle.
- Store with wait states: dm_we_i=1, be=4'b0011, wdata=0xDEADBEEF, mem_gnt_i delayed 3 cycles -> mem outputs stable 3 cycles, dm_gnt_o only in the gnt cycle, dm_rvalid_o on response.
- Spurious response: mem_rvalid_i=1 while IDLE -> no rvalid_o; state stays IDLE.
- Reset in RSP: rst_i pulsed before rvalid -> all outputs 0 immediately; a late mem_rvalid_i is ignored.
- ARB_FAIRNESS_EN, STARVE_LIMIT=4: both requests continuously high -> 4 DM transactions, then 1 IF, then DM again. Without the macro: IF never granted.
